// File: rtl/counter_period_controller_if.sv
// Counter-side bus: the controller (master) drives load/data/enable into a
// loadable up-counter (slave) and receives its terminal-count pulse.
`timescale 1ns/1ps
interface counter_period_controller_if #(
    parameter int DATA_W = 4
);
    logic              load;
    logic [DATA_W-1:0] data;
    logic              enable;
    logic              cout;

    modport master (output load, output data, output enable, input cout);
    modport slave  (input load, input data, input enable, output cout);
endinterface

// File: rtl/counter_period_controller.sv
// Runs a requested number of counter periods, reloading the counter after each
// cout, with abort, watchdog timeout and progress reporting.
`timescale 1ns/1ps
module counter_period_controller #(
    parameter int DATA_W  = 4,
    parameter int REP_W   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    // Job handshake: a job is accepted on the rising edge where start && start_ready.
    // The requester holds start (and its data) until that edge; start_ready is high only in IDLE.
    input  logic                       start,
    output logic                       start_ready,
    input  logic [DATA_W-1:0]          period_data,
    input  logic [REP_W-1:0]           repeat_cnt,
    input  logic                       abort,
    counter_period_controller_if.master cnt,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout_err,
    output logic [REP_W-1:0]           periods_done,
    output logic [2:0]                 state_dbg
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] period_q, period_n;
    logic [REP_W-1:0]  repeat_q, repeat_n;
    logic [REP_W-1:0]  pdone_n;
    logic [WD_W-1:0]   wd, wd_n;
    logic              load_q, enable_q;

    always_comb begin
        state_n  = state;
        period_n = period_q;
        repeat_n = repeat_q;
        pdone_n  = periods_done;
        wd_n     = wd;
        case (state)
            S_IDLE: begin
                if (start) begin
                    period_n = period_data;
                    repeat_n = repeat_cnt;
                    pdone_n  = '0;
                    state_n  = (repeat_cnt == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                wd_n    = '0;
                state_n = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                // abort beats cout, and a cout in the watchdog's last cycle still counts
                if (abort) begin
                    state_n = S_IDLE;
                end else if (cnt.cout) begin
                    pdone_n = periods_done + 1'b1;
                    state_n = (pdone_n == repeat_q) ? S_DONE : S_LOAD;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    state_n = S_ERR;
                end else if (wd != '1) begin
                    wd_n = wd + 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            period_q     <= '0;
            repeat_q     <= '0;
            wd           <= '0;
            periods_done <= '0;
            start_ready  <= 1'b1;
            load_q       <= 1'b0;
            enable_q     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_n;
            period_q     <= period_n;
            repeat_q     <= repeat_n;
            wd           <= wd_n;
            periods_done <= pdone_n;
            start_ready  <= (state_n == S_IDLE);
            load_q       <= (state_n == S_LOAD);
            enable_q     <= (state_n == S_RUN);
            busy         <= (state_n == S_LOAD) || (state_n == S_RUN);
            done         <= (state_n == S_DONE);
            timeout_err  <= (state_n == S_ERR);
        end
    end

    assign cnt.load   = load_q;
    assign cnt.data   = period_q;
    assign cnt.enable = enable_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_counter_period_controller.sv
// Scoreboard bench: job timing is predicted from period arithmetic and checked
// by a monitor that pops expected load pulses and end events.
`timescale 1ns/1ps
module tb_counter_period_controller;
    localparam int DATA_W  = 4;
    localparam int REP_W   = 8;
    localparam int TIMEOUT = 32;
    localparam int SPAN    = 1 << DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [DATA_W-1:0] period_data = '0;
    logic [REP_W-1:0]  repeat_cnt = '0;
    logic              start_ready, busy, done, timeout_err;
    logic [REP_W-1:0]  periods_done;
    logic [2:0]        state_dbg;

    counter_period_controller_if #(.DATA_W(DATA_W)) cbus();

    counter_period_controller #(.DATA_W(DATA_W), .REP_W(REP_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .start_ready(start_ready),
        .period_data(period_data), .repeat_cnt(repeat_cnt), .abort(abort),
        .cnt(cbus), .busy(busy), .done(done), .timeout_err(timeout_err),
        .periods_done(periods_done), .state_dbg(state_dbg)
    );

    // clock/reset block
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural counter with optional cout override
    logic [DATA_W-1:0] count = '0;
    logic force_mode = 1'b0;
    logic force_cout = 1'b0;
    always @(posedge clk) begin
        if (cbus.load) count <= cbus.data;
        else if (cbus.enable) count <= count + 1'b1;
    end
    assign cbus.cout = force_mode ? force_cout : (cbus.enable && (count == '1));

    // scoreboard
    logic [31:0] exp_q[$];   // {kind, pdone, cycle}; kind 1=done 2=timeout
    logic [31:0] load_q[$];  // {data, cycle}
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (done || timeout_err) begin
                check("end_event_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    check("end_event", {6'd0, timeout_err, done, periods_done, 16'(cyc)}, exp_q.pop_front());
            end
            if (cbus.load) begin
                check("load_expected", 32'(load_q.size() != 0), 32'd1);
                if (load_q.size() != 0)
                    check("load_pulse", {12'd0, cbus.data, 16'(cyc)}, load_q.pop_front());
            end
        end
    end

    // reference model: each period is one LOAD cycle plus (SPAN - p) RUN cycles
    task automatic push_expect(input int kind, input int a, input int p, input int r);
        int per;
        per = 1 + SPAN - p;
        case (kind)
            0: begin
                for (int i = 0; i < r; i++) load_q.push_back({12'd0, 4'(p), 16'(a + 1 + i * per)});
                exp_q.push_back({8'd1, 8'(r), 16'(a + 1 + r * per)});
            end
            1: begin
                load_q.push_back({12'd0, 4'(p), 16'(a + 1)});
                exp_q.push_back({8'd2, 8'd0, 16'(a + TIMEOUT + 2)});
            end
            2: begin
                load_q.push_back({12'd0, 4'(p), 16'(a + 1)});
                load_q.push_back({12'd0, 4'(p), 16'(a + 1 + per)});
            end
            3: load_q.push_back({12'd0, 4'(p), 16'(a + 1)});
            default: begin
                load_q.push_back({12'd0, 4'(p), 16'(a + 1)});
                exp_q.push_back({8'd1, 8'd1, 16'(a + TIMEOUT + 2)});
            end
        endcase
    endtask

    // driver tasks
    task automatic accept_job(input int kind, input int p, input int r, output int a);
        int n;
        n = 0;
        @(negedge clk);
        period_data = DATA_W'(p);
        repeat_cnt  = REP_W'(r);
        start       = 1'b1;
        while (!start_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 32'(n < 500), 32'd1);
        a = cyc;
        push_expect(kind, a, p, r);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(start_ready && !done && !timeout_err) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_in_time", 32'(n < 2000), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_start_ready"}, start_ready, 1);
        check({tag, "_load"}, cbus.load, 0);
        check({tag, "_enable"}, cbus.enable, 0);
        check({tag, "_data"}, cbus.data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_periods_done"}, periods_done, 0);
    endtask

    initial begin
        int a, p, r, len;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;

        // directed: p=12, r=3 -> loads +1,+6,+11, done +16
        accept_job(0, 12, 3, a);
        wait_idle();
        check("pd_basic", periods_done, 3);

        // repeat_cnt == 0 -> done at +1, no load
        accept_job(0, 5, 0, a);
        check("r0_enable", cbus.enable, 0);
        wait_idle();
        check("pd_r0", periods_done, 0);

        // watchdog with cout held low
        force_mode = 1'b1;
        force_cout = 1'b0;
        accept_job(1, 0, 2, a);
        wait_idle();
        check("pd_timeout", periods_done, 0);

        // cout in the last watchdog cycle is counted
        accept_job(4, 3, 1, a);
        repeat (TIMEOUT) @(negedge clk);
        force_cout = 1'b1;
        @(negedge clk);
        force_cout = 1'b0;
        wait_idle();
        check("pd_cout_at_limit", periods_done, 1);
        force_mode = 1'b0;

        // abort in the second RUN period
        p = 9;
        len = SPAN - p;
        accept_job(2, p, 5, a);
        repeat (len + 2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_start_ready", start_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_enable", cbus.enable, 0);
        check("abort_pd", periods_done, 1);

        // abort together with cout: cout not counted
        p = 11;
        len = SPAN - p;
        accept_job(3, p, 4, a);
        repeat (len) @(negedge clk);
        check("abort_cout_present", cbus.cout, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_cout_ready", start_ready, 1);
        check("abort_cout_pd", periods_done, 0);

        // async reset mid-RUN
        accept_job(0, 8, 4, a);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_values("async_reset");
        exp_q.delete();
        load_q.delete();
        @(negedge clk);
        reset = 1'b1;
        accept_job(0, 14, 2, a);
        wait_idle();
        check("pd_after_reset", periods_done, 2);

        // randomized jobs
        for (int j = 0; j < 12; j++) begin
            p = $urandom_range(0, SPAN - 1);
            r = $urandom_range(0, 6);
            accept_job(0, p, r, a);
            wait_idle();
            check("pd_random", periods_done, 32'(r));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("end_queue_empty", 32'(exp_q.size()), 0);
        check("load_queue_empty", 32'(load_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/counter_period_controller.md
Name: counter_period_controller

Overview:
- Master side of the load/data/enable/cout interface of the loadable up-counter DUT.
- Drives load, data and enable into the counter and consumes its cout terminal-count pulse.
- Runs a requested number of counter periods, reloading the counter after every cout.
- Reports completion, progress, abort and watchdog timeout; sits between a test or control sequencer and the counter.

Parameters:
- DATA_W, 4, counter width; width of data/period_data.
- REP_W, 8, width of repeat_cnt/periods_done.
- TIMEOUT, 32, max consecutive RUN cycles without cout before error (must be > 2**DATA_W).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low; assertion forces all state/outputs to reset values immediately.
- start  in  1  job request; accepted on clk edge where start && start_ready.
- start_ready  out  1  high only in IDLE.
- period_data  in  DATA_W  counter load value, captured at accept.
- repeat_cnt  in  REP_W  number of cout periods to run, captured at accept.
- abort  in  1  cancel current job.
- load  out  1  counter synchronous load strobe.
- data  out  DATA_W  counter load value.
- enable  out  1  counter count enable.
- cout  in  1  counter terminal-count pulse.
- busy  out  1  high in LOAD/RUN.
- done  out  1  one-cycle completion pulse.
- timeout_err  out  1  one-cycle watchdog error pulse.
- periods_done  out  REP_W  couts counted in current/last job.

Behaviour:
- Reset values: state=IDLE, start_ready=1, load=0, enable=0, data=0, busy=0, done=0, timeout_err=0, periods_done=0, watchdog=0. All outputs registered.
- FSM states: IDLE, LOAD, RUN, DONE, ERR.
- IDLE, on accept:
  - capture period_data and repeat_cnt; clear periods_done.
  - repeat_cnt==0 -> DONE; else -> LOAD.
- LOAD (one cycle): load=1, data=captured value, enable=0, busy=1; clear watchdog; -> RUN.
- RUN: enable=1, load=0, busy=1; watchdog increments each cycle cout=0.
- RUN, cout=1:
  - periods_done+1.
  - If new value == captured repeat_cnt -> DONE; else -> LOAD (reload).
- RUN, watchdog reaches TIMEOUT-1 with cout=0 -> ERR.
- DONE: done=1 for exactly one cycle, enable=0; -> IDLE.
- ERR: timeout_err=1 for exactly one cycle, enable=0; -> IDLE; periods_done holds partial count.
- abort in LOAD/RUN -> IDLE next cycle; load/enable/busy drop; no done, no timeout_err; periods_done holds.
- abort in IDLE/DONE/ERR is ignored.
- Priority in RUN, same cycle: abort > cout > timeout. cout in the timeout cycle is counted and no error is raised.
- cout outside RUN is ignored and not counted.
- periods_done holds after DONE/ERR/abort until the next accept.
- start while busy is not accepted (start_ready=0); the request must be held by the requester.
- Period per iteration = 1 LOAD cycle + (2**DATA_W - period_data) RUN cycles, for a counter with cout = enable && count==max.
- Watchdog width = clog2(TIMEOUT+1); saturates and never wraps.

Test Plan:
- Reset mid-RUN (reset=0 asynchronously): outputs return to reset values immediately, without waiting for a clk edge. After release, start_ready=1 and the next job runs normally.
- DATA_W=4, period_data=12, repeat_cnt=3, behavioural counter model:
  - load pulses at accept+1, +6, +11.
  - couts at +5, +10, +15.
  - done at +16; periods_done=3.
- repeat_cnt=0: done at accept+1; no load/enable ever asserted; periods_done=0.
- cout tied 0, period_data=0: timeout_err after TIMEOUT RUN cycles, then start_ready=1; periods_done=0; no done.
- abort during second RUN period (repeat_cnt=5): IDLE next cycle; periods_done=1; no done/timeout_err; following job completes normally.
- Simultaneous abort and cout in RUN: cout not counted, abort wins. Separately, cout exactly at TIMEOUT-1: counted, no timeout_err.
